alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
- Multi-cycle control sequencer on the command side of the 8-bit datapath ALU.
- Fetches 8-bit instruction bytes from program memory through a request/valid handshake.
- Decodes each byte into the 4-bit aluop and the register write enable. It latches the ALU's {S,Z,Cy} status into a flag register, feeds Cy back as the carry-in, and evaluates conditional jumps on those flags.
- Sits between program memory and the datapath (ALU plus register file).

Parameters:
- PC_RESET, 8'h00, program counter value loaded on reset and on each start.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins execution from IDLE.
- mem_req  output  1  instruction or operand byte request.
- mem_addr  output  8  fetch address; always equals pc.
- mem_valid  input  1  fetched byte is present on mem_data this cycle.
- mem_data  input  8  fetched byte.
- SZCy  input  3  ALU status {S,Z,Cy} for the current aluop.
- aluop  output  4  ALU operation select.
- Cy_in  output  1  carry into the ALU; equals flags[0].
- reg_we  output  1  write the ALU result to the register file.
- rd_sel  output  2  destination register; equals ir[5:4].
- flags  output  3  registered {S,Z,Cy}.
- pc  output  8  program counter.
- busy  output  1  high in every state except IDLE.
- halted  output  1  high for exactly one cycle when a HALT instruction is decoded.

Behaviour:
- Reset values: state=IDLE, pc=PC_RESET, ir=0, flags=3'b000. All other outputs are 0, including mem_req, reg_we, aluop, busy and halted.
- Reset asserted in any state, including while a fetch is pending, aborts the sequence. A mem_valid arriving in the same cycle is ignored.
- Instruction classes, selected by ir[7:6]:
  - 00 ALU: aluop=ir[3:0]; writes the result to register ir[5:4]; updates flags.
  - 01 CMP: aluop=ir[3:0]; updates flags only, no register write.
  - 10 JMP: two-byte instruction; the second byte is the target address. Condition ir[5:4]: 00 always, 01 Z, 10 Cy, 11 S.
  - 11 HALT: ir[5:0] ignored.
- State machine:
  - IDLE: on start, pc<=PC_RESET and go to FETCH. Otherwise stay.
  - FETCH: mem_req=1. Wait any number of cycles for mem_valid. On mem_valid: ir<=mem_data, pc<=pc+1, go to DECODE.
  - DECODE (1 cycle):
    - ALU or CMP: go to EXEC.
    - JMP with condition true: go to FETCH_OP.
    - JMP with condition false: pc<=pc+1 (skips the target byte), go to FETCH.
    - HALT: halted=1 this cycle, go to IDLE.
  - EXEC (1 cycle): aluop=ir[3:0]; reg_we=1 for the ALU class only; flags<=SZCy; go to FETCH.
  - FETCH_OP: mem_req=1. On mem_valid: pc<=mem_data, go to FETCH.
- aluop is driven only in EXEC and is 4'b0000 in every other state. SZCy is sampled only at the EXEC clock edge.
- Cy_in=flags[0] combinationally. Ops 1100 and 1101 therefore use the carry stored by the previous ALU or CMP instruction.
- Jump conditions use the flags value held at DECODE.
- Cycle counts with zero memory wait: ALU/CMP takes 3 cycles (FETCH, DECODE, EXEC), a taken JMP takes 3, a not-taken JMP takes 2.
- pc arithmetic is modulo 256: 8'hFF+1 wraps to 8'h00, on both the fetch increment and the skip increment.
- Handshake:
  - mem_valid outside FETCH and FETCH_OP is ignored.
  - mem_req stays high with a stable mem_addr until mem_valid is seen.
- start outside IDLE is ignored. A start in the same cycle as reset loses; the block stays in IDLE.

Test Plan:
- Reset, then start. Memory returns 8'h1A at address 00 with zero wait, SZCy=3'b000 at EXEC. Required: FETCH, DECODE, EXEC sequence; aluop=4'hA and reg_we=1, rd_sel=2'b01 in EXEC; pc=01; back in FETCH.
- CMP byte 8'h4B with SZCy=3'b010 at EXEC. Required: reg_we=0, flags=3'b010 after EXEC. Then JMP 8'h90 with target byte 8'h40: pc=8'h40 and mem_addr=8'h40 on the next FETCH.
- flags Z=0, JMP 8'h90 at address 05. Required: not taken, next fetch at address 07, FETCH_OP never entered.
- Set Cy=1 via an ALU op with SZCy=3'b001, then ALU byte 8'h0C. Required: Cy_in=1 during EXEC, aluop=4'hC.
- Fetch at pc=8'hFF of an ALU byte. Required: pc=8'h00 after the fetch. Also hold mem_valid low for 4 cycles: mem_req and mem_addr stay stable, no state advance.
- HALT 8'hC0. Required: one-cycle halted pulse, then IDLE with busy=0; start ignored while busy. Reset asserted mid-FETCH: next cycle shows IDLE, pc=00, mem_req=0, flags=000.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Command-side sequencer for the 8-bit ALU datapath: fetches instruction bytes,
// decodes them into aluop/reg_we, holds the {S,Z,Cy} flags and resolves jumps.
module alu_ctrl_seq #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_valid,
    input  logic [7:0] mem_data,
    input  logic [2:0] SZCy,
    output logic [3:0] aluop,
    output logic       Cy_in,
    output logic       reg_we,
    output logic [1:0] rd_sel,
    output logic [2:0] flags,
    output logic [7:0] pc,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_FETCH_OP
    } state_t;

    typedef enum logic [1:0] {
        C_ALU  = 2'b00,
        C_CMP  = 2'b01,
        C_JMP  = 2'b10,
        C_HALT = 2'b11
    } cls_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [2:0] r_flags;
    cls_t       w_cls;
    logic       w_taken;

    assign w_cls = cls_t'(r_ir[7:6]);

    // Jump condition in ir[5:4] selects always / Z / Cy / S from the held flags.
    always_comb begin
        unique case (r_ir[5:4])
            2'b00:   w_taken = 1'b1;
            2'b01:   w_taken = r_flags[1];
            2'b10:   w_taken = r_flags[0];
            default: w_taken = r_flags[2];
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= PC_RESET;
            r_ir    <= 8'h00;
            r_flags <= 3'b000;
        end else begin
            unique case (r_state)
                S_IDLE: if (start) r_pc <= PC_RESET;
                S_FETCH: begin
                    if (mem_valid) begin
                        r_ir <= mem_data;
                        r_pc <= r_pc + 8'd1;
                    end
                end
                S_DECODE: if (w_cls == C_JMP && !w_taken) r_pc <= r_pc + 8'd1;
                S_EXEC:     r_flags <= SZCy;
                S_FETCH_OP: if (mem_valid) r_pc <= mem_data;
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case below can leave one unassigned and infer a latch.
    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        aluop   = 4'b0000;
        reg_we  = 1'b0;
        halted  = 1'b0;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                unique case (w_cls)
                    C_ALU, C_CMP: w_next = S_EXEC;
                    C_JMP:        w_next = w_taken ? S_FETCH_OP : S_FETCH;
                    default: begin
                        halted = 1'b1;
                        w_next = S_IDLE;
                    end
                endcase
            end
            S_EXEC: begin
                aluop  = r_ir[3:0];
                reg_we = (w_cls == C_ALU);
                w_next = S_FETCH;
            end
            S_FETCH_OP: begin
                mem_req = 1'b1;
                if (mem_valid) w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign flags    = r_flags;
    assign Cy_in    = r_flags[0];
    assign rd_sel   = r_ir[5:4];
    assign busy     = (r_state != S_IDLE);

endmodule
